// File: rtl/processor_pkg.sv
// Shared types and constants for the processor front end.
package processor_pkg;

    localparam int unsigned WORD_WIDTH  = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // Fetch-unit control states: issue normally, or wait out stale responses.
    typedef enum logic {
        StFetch,
        StFlush
    } fetch_state_e;

    // One buffered fetch result as seen by decode.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] instruction;
        logic [WORD_WIDTH-1:0] pc;
    } fetch_entry_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
        return {addr[WORD_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count, flop-based head and a clear that
// overrides any same-cycle push or pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en, pop_en;

    // Next-state for pointers and count; clear wins over push/pop.
    always_comb begin
        push_en  = push_i && !clear_i;
        pop_en   = pop_i && !clear_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates validity.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited in-order memory requests,
// stale-response dropping after redirects, and a result FIFO towards decode.
// Optional performance counters are built when IFETCH_PERF_COUNT_EN is defined.
module instruction_fetch_unit
    import processor_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_request_valid,
    input  logic        imem_request_ready,
    output logic [31:0] imem_request_address,
    input  logic        imem_response_valid,
    input  logic [31:0] imem_response_data,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
`ifdef IFETCH_PERF_COUNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    // PC of the next response that will actually be kept.
    logic [WORD_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0]       outstanding_q, outstanding_d;
    logic [CntW-1:0]       drop_q, drop_d;
    // Holds request issue off for the first cycle out of reset.
    logic                  active_q;

    logic [CntW-1:0]       fifo_count;
    logic                  fifo_empty;
    logic [CntW:0]         in_use;
    logic                  req_xfer;
    logic                  resp_keep;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;

    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req_xfer  = imem_request_valid && imem_request_ready;
    assign resp_keep = imem_response_valid && (drop_q == '0);

    // Request channel: issue only in FETCH and only with a free FIFO slot reserved.
    always_comb begin
        imem_request_valid   = active_q && (state_q == StFetch) && (in_use < (CntW+1)'(DEPTH));
        imem_request_address = pc_q;
    end

    // Next-state: PC, in-flight bookkeeping and FSM; redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        if (req_xfer) begin
            pc_d          = pc_q + WORD_WIDTH'(INSTR_BYTES);
            outstanding_d = outstanding_d + CntW'(1);
        end

        if (imem_response_valid) begin
            outstanding_d = outstanding_d - CntW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CntW'(1);
            end else begin
                resp_pc_d = resp_pc_q + WORD_WIDTH'(INSTR_BYTES);
            end
        end

        if ((state_q == StFlush) && (drop_d == '0)) state_d = StFetch;

        if (redirect_valid) begin
            pc_d      = align_word(redirect_pc);
            resp_pc_d = align_word(redirect_pc);
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d    = outstanding_d;
            state_d   = (outstanding_d != '0) ? StFlush : StFetch;
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            active_q      <= 1'b1;
        end
    end

    assign push_entry = '{instruction: imem_response_data, pc: resp_pc_q};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .clear_i     (redirect_valid),
        .push_i      (resp_keep),
        .push_data_i (push_entry),
        .pop_i       (fetch_valid && fetch_ready),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign fetch_valid       = !fifo_empty;
    assign fetch_instruction = head_entry.instruction;
    assign fetch_pc          = head_entry.pc;

`ifdef IFETCH_PERF_COUNT_EN
    logic [31:0] stall_q, flush_q;

    // Saturating stall and redirect counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (fetch_ready && !fetch_valid && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (redirect_valid && (flush_q != '1)) flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: randomized memory/decode/redirect stimulus,
// a stream-level reference model and a scoreboard checked at decode.
// Perf-counter checks are built when IFETCH_PERF_COUNT_EN is defined.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_request_valid, imem_request_ready;
    logic [31:0] imem_request_address;
    logic        imem_response_valid;
    logic [31:0] imem_response_data;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_instruction, fetch_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_fv, w_fready;
    logic [31:0] w_finstr, w_fpc;
    logic        w_redir_valid;
    logic [31:0] w_redir_pc;
`ifdef IFETCH_PERF_COUNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_count, w_perf_stall, w_perf_flush;
`endif

    always #5 clock = ~clock;

    instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock                (clock),
        .reset                (reset),
        .imem_request_valid   (imem_request_valid),
        .imem_request_ready   (imem_request_ready),
        .imem_request_address (imem_request_address),
        .imem_response_valid  (imem_response_valid),
        .imem_response_data   (imem_response_data),
        .fetch_valid          (fetch_valid),
        .fetch_ready          (fetch_ready),
        .fetch_instruction    (fetch_instruction),
        .fetch_pc             (fetch_pc),
`ifdef IFETCH_PERF_COUNT_EN
        .perf_stall_cycles    (perf_stall_cycles),
        .perf_flush_count     (perf_flush_count),
`endif
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc)
    );

    instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock                (clock),
        .reset                (reset),
        .imem_request_valid   (w_req_valid),
        .imem_request_ready   (w_req_ready),
        .imem_request_address (w_req_addr),
        .imem_response_valid  (w_resp_valid),
        .imem_response_data   (w_resp_data),
        .fetch_valid          (w_fv),
        .fetch_ready          (w_fready),
        .fetch_instruction    (w_finstr),
        .fetch_pc             (w_fpc),
`ifdef IFETCH_PERF_COUNT_EN
        .perf_stall_cycles    (w_perf_stall),
        .perf_flush_count     (w_perf_flush),
`endif
        .redirect_valid       (w_redir_valid),
        .redirect_pc          (w_redir_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_req_t    mem_q[$];
    mem_req_t    resp_cur;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] dq[$];
    logic [31:0] acc_log[$];
    logic [31:0] w_log[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_del = 0;
    int          cyc = 0;
    int unsigned epoch = 0;
    logic [31:0] model_pc = 32'h0;
    logic        s_fv, s_rv;

    int          p_ready = 100;
    int          p_fready = 100;
    int          p_redir = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          accept_budget = -1;
    bit          do_redir = 1'b0;
    logic [31:0] redir_target = 32'h0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode-side monitor: every handshake must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && fetch_valid && fetch_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL decode_unexpected: got pc %h instr %h, required no entry (t=%0t)",
                         fetch_pc, fetch_instruction, $time);
            end else begin
                mon_e = sb.pop_front();
                check("decode_pc", fetch_pc, mon_e.pc);
                check("decode_instr", fetch_instruction, mon_e.instr);
            end
            dq.push_back(fetch_pc);
            n_del++;
        end
    end

    // One clock: sample at negedge, account events at posedge, drive the next cycle.
    task automatic step();
        logic        s_req, s_resp, s_redir, s_wreq;
        logic [31:0] s_addr, s_rpc, s_waddr;
        @(negedge clock);
        s_req   = imem_request_valid && imem_request_ready;
        s_addr  = imem_request_address;
        s_resp  = imem_response_valid;
        s_redir = redirect_valid;
        s_rpc   = redirect_pc;
        s_fv    = fetch_valid;
        s_rv    = imem_request_valid;
        s_wreq  = w_req_valid && w_req_ready;
        s_waddr = w_req_addr;
        @(posedge clock);
        if (s_req) begin
            check("req_addr", s_addr, model_pc);
            acc_log.push_back(s_addr);
            mem_q.push_back('{addr: s_addr, epoch: epoch,
                              due: cyc + int'($urandom_range(lat_hi, lat_lo))});
            model_pc = model_pc + 32'd4;
            n_acc++;
            if (accept_budget > 0) accept_budget--;
        end
        if (s_resp && (resp_cur.epoch == epoch))
            sb.push_back('{pc: resp_cur.addr, instr: instr_of(resp_cur.addr)});
        if (s_redir) begin
            sb.delete();
            dq.delete();
            acc_log.delete();
            epoch++;
            model_pc = {s_rpc[31:2], 2'b00};
        end
        if (s_wreq) w_log.push_back(s_waddr);
        cyc++;
        #1;
        if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
            resp_cur            = mem_q.pop_front();
            imem_response_valid = 1'b1;
            imem_response_data  = instr_of(resp_cur.addr);
        end else begin
            imem_response_valid = 1'b0;
            imem_response_data  = $urandom;
        end
        imem_request_ready = (accept_budget != 0) && (int'($urandom_range(99)) < p_ready);
        fetch_ready        = int'($urandom_range(99)) < p_fready;
        if (do_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            do_redir       = 1'b0;
        end else if (int'($urandom_range(999)) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
        end else begin
            redirect_valid = 1'b0;
        end
        w_resp_valid = s_wreq;
        w_resp_data  = instr_of(s_waddr);
    endtask

    // Reset DUTs and the memory/bench model together.
    task automatic do_reset();
        reset               = 1'b1;
        imem_request_ready  = 1'b0;
        imem_response_valid = 1'b0;
        imem_response_data  = 32'h0;
        fetch_ready         = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        w_resp_valid        = 1'b0;
        w_resp_data         = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mem_q.delete();
        sb.delete();
        dq.delete();
        acc_log.delete();
        w_log.delete();
        epoch++;
        model_pc      = 32'h0;
        cyc           = 0;
        accept_budget = -1;
        do_redir      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        w_req_ready   = 1'b1;
        w_fready      = 1'b1;
        w_redir_valid = 1'b0;
        w_redir_pc    = 32'h0;

        // Streaming with a 1-cycle memory and a always-ready decode.
        p_ready = 100; p_fready = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 0) begin
                check("rst_req_valid", 32'(s_rv), 32'd0);
                check("rst_fetch_valid", 32'(s_fv), 32'd0);
            end
            if (c >= 3) check("t1_stream_valid", 32'(s_fv), 32'd1);
        end

        // Second instance starts near the top of the address space.
        check("t5_req_count", 32'(w_log.size() >= 3), 32'd1);
        if (w_log.size() >= 3) begin
            check("t5_addr0", w_log[0], 32'hFFFF_FFF8);
            check("t5_addr1", w_log[1], 32'hFFFF_FFFC);
            check("t5_addr2", w_log[2], 32'h0000_0000);
        end

        // Decode stalled: issue stops at the FIFO depth, then drains in order.
        do_reset();
        p_fready = 0; n_acc = 0;
        repeat (20) step();
        check("t2_req_count", 32'(n_acc), 32'd4);
        check("t2_req_valid_full", 32'(s_rv), 32'd0);
        p_fready = 100; n_del = 0;
        repeat (12) step();
        check("t2_drained", 32'(n_del >= 4), 32'd1);

        // Redirect with three requests in flight on a slow memory.
        do_reset();
        lat_lo = 5; lat_hi = 5; accept_budget = 3; n_acc = 0;
        for (int c = 0; (c < 40) && (n_acc < 3); c++) step();
        check("t3_three_issued", 32'(n_acc), 32'd3);
        redir_target = 32'h0000_0103; do_redir = 1'b1;
        step();
        step();
        accept_budget = -1;
        repeat (30) step();
        check("t3_first_req", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);
        check("t3_first_pc", (dq.size() > 0) ? dq[0] : 32'hDEAD_BEEF, 32'h0000_0100);

        // Redirect landing on a cycle with a response, a push and a pop.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (10) step();
        redir_target = 32'h0000_2000; do_redir = 1'b1;
        step();
        step();
        check("t4_pop_coincident", 32'(s_fv), 32'd1);
        step();
        check("t4_flushed", 32'(s_fv), 32'd0);
        repeat (15) step();
        check("t4_first_pc", (dq.size() > 0) ? dq[0] : 32'hDEAD_BEEF, 32'h0000_2000);

        // Randomized traffic with redirects to arbitrary addresses.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            p_ready  = int'($urandom_range(100, 30));
            p_fready = int'($urandom_range(100, 20));
            lat_lo   = 1;
            lat_hi   = int'($urandom_range(6, 1));
            p_redir  = 30;
            n_del    = 0;
            repeat (400) step();
            check("rand_progress", 32'(n_del > 0), 32'd1);
        end

`ifdef IFETCH_PERF_COUNT_EN
        // Seven idle-decode cycles with an empty FIFO, then two redirects.
        do_reset();
        p_ready = 0; p_fready = 100; p_redir = 0;
        repeat (7) step();
        p_fready = 0;
        redir_target = 32'h40; do_redir = 1'b1;
        step();
        redir_target = 32'h80; do_redir = 1'b1;
        step();
        repeat (3) step();
        check("perf_stall", perf_stall_cycles, 32'd7);
        check("perf_flush", perf_flush_count, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
